// File: rtl/johnson_pkg.sv
// Shared definitions for Johnson-code decoding: FSM states plus the legality
// and index functions used by the decoder and by the counter's checker.
package johnson_pkg;

  typedef enum logic [1:0] {
    UNLOCKED,
    ACQUIRE,
    LOCKED
  } state_t;

  // Widest code word the helper functions accept; narrower words are zero-extended.
  localparam int MAX_N = 32;

  function automatic int ones(input logic [MAX_N-1:0] w);
    int k;
    k = 0;
    for (int i = 0; i < MAX_N; i++) begin
      k += int'(w[i]);
    end
    return k;
  endfunction

  function automatic logic johnson_legal(input logic [MAX_N-1:0] w, input int n);
    int k;
    logic [MAX_N-1:0] low_run;
    logic [MAX_N-1:0] high_run;
    k        = ones(w);
    low_run  = '0;
    high_run = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (i < k) low_run[i] = 1'b1;
      if ((i < n) && (i >= n - k)) high_run[i] = 1'b1;
    end
    if (k == 0) return 1'b1;
    if (w[n-1]) return (w == high_run);
    if (w[0]) return (w == low_run);
    return 1'b0;
  endfunction

  // Only meaningful for legal words; the filling half counts up, the draining half counts on from n.
  function automatic int johnson_index(input logic [MAX_N-1:0] w, input int n);
    int k;
    k = ones(w);
    if (k == 0) return 0;
    if (w[n-1]) return k;
    return 2 * n - k;
  endfunction

endpackage

// File: rtl/johnson_word_decode.sv
// Combinational legality check and index decode of one Johnson code word.
module johnson_word_decode #(
  parameter int N = 4,
  localparam int IW = $clog2(2 * N)
) (
  input  logic [N-1:0]  code,
  output logic          legal,
  output logic [IW-1:0] idx
);
  import johnson_pkg::*;

  logic [MAX_N-1:0] word;

  assign word  = MAX_N'(code);
  assign legal = johnson_legal(word, N);
  assign idx   = IW'(johnson_index(word, N));

endmodule

// File: rtl/johnson_decoder.sv
// Decodes a sampled Johnson code stream to a count index, checks successor
// order, tracks lock status and keeps a saturating error tally.
module johnson_decoder #(
  parameter int N = 4,
  parameter int LOCK_CNT = 2,
  localparam int IW = $clog2(2 * N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  code_in,
  input  logic          code_vld,
  input  logic          err_clr,
  output logic [IW-1:0] count,
  output logic          count_vld,
  output logic          illegal,
  output logic          seq_err,
  output logic          locked,
  output logic [7:0]    err_cnt
);
  import johnson_pkg::*;

  localparam logic [IW-1:0] LAST_IDX = IW'(2 * N - 1);

  state_t        state, state_next;
  logic [3:0]    run, run_next;
  logic          legal;
  logic [IW-1:0] idx;
  logic [IW-1:0] succ_idx;
  logic          is_succ;
  logic          bad_word;
  logic          seq_fault;

  johnson_word_decode #(.N(N)) u_word_decode (
    .code  (code_in),
    .legal (legal),
    .idx   (idx)
  );

  // count doubles as the previous-index register: both load on every legal sample.
  assign succ_idx = (count == LAST_IDX) ? '0 : count + 1'b1;
  assign is_succ  = (idx == succ_idx);
  assign locked   = (state == LOCKED);

  always_comb begin
    state_next = state;
    run_next   = run;
    bad_word   = 1'b0;
    seq_fault  = 1'b0;
    if (code_vld) begin
      if (!legal) begin
        bad_word   = 1'b1;
        state_next = UNLOCKED;
        run_next   = '0;
      end else begin
        case (state)
          UNLOCKED: begin
            state_next = ACQUIRE;
            run_next   = '0;
          end
          ACQUIRE: begin
            if (is_succ) begin
              run_next = run + 4'd1;
              if (run_next == 4'(LOCK_CNT)) state_next = LOCKED;
            end else begin
              run_next = '0;
            end
          end
          LOCKED: begin
            if (!is_succ) begin
              seq_fault  = 1'b1;
              state_next = UNLOCKED;
              run_next   = '0;
            end
          end
          default: begin
            state_next = UNLOCKED;
            run_next   = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= UNLOCKED;
      run   <= '0;
    end else begin
      state <= state_next;
      run   <= run_next;
    end
  end

  // err_clr wins over a simultaneous error so software always sees a clean zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      count_vld <= 1'b0;
      illegal   <= 1'b0;
      seq_err   <= 1'b0;
      err_cnt   <= '0;
    end else begin
      count_vld <= code_vld & legal;
      illegal   <= bad_word;
      seq_err   <= seq_fault;
      if (code_vld && legal) count <= idx;
      if (err_clr) begin
        err_cnt <= '0;
      end else if ((bad_word || seq_fault) && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_johnson_decoder.sv
// Directed bench for johnson_decoder (N=4, LOCK_CNT=2) with a table-driven
// reference model checked every cycle plus literal spot checks.
module tb_johnson_decoder;

  localparam int N = 4;
  localparam int LOCK_CNT = 2;
  localparam int LEN = 2 * N;

  logic       clk;
  logic       rst_n;
  logic [3:0] code_in;
  logic       code_vld;
  logic       err_clr;
  logic [2:0] count;
  logic       count_vld;
  logic       illegal;
  logic       seq_err;
  logic       locked;
  logic [7:0] err_cnt;

  int checks = 0;
  int errors = 0;
  bit check_en = 0;

  johnson_decoder #(.N(N), .LOCK_CNT(LOCK_CNT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .code_in   (code_in),
    .code_vld  (code_vld),
    .err_clr   (err_clr),
    .count     (count),
    .count_vld (count_vld),
    .illegal   (illegal),
    .seq_err   (seq_err),
    .locked    (locked),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ring built by shifting the inverted last stage into the first.
  logic [3:0] ring [LEN];
  initial begin
    logic [3:0] w;
    w = 4'b0000;
    for (int i = 0; i < LEN; i++) begin
      ring[i] = w;
      w = {~w[0], w[3:1]};
    end
  end

  function automatic int lookup(input logic [3:0] w);
    for (int i = 0; i < LEN; i++) begin
      if (ring[i] == w) return i;
    end
    return -1;
  endfunction

  int m_count = 0;
  int m_count_vld = 0;
  int m_illegal = 0;
  int m_seq_err = 0;
  int m_err = 0;
  int m_streak = 0;
  bit m_have_prev = 0;

  // Lock = an unbroken streak of at least LOCK_CNT correct successors.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_count = 0; m_count_vld = 0; m_illegal = 0; m_seq_err = 0;
      m_err = 0; m_streak = 0; m_have_prev = 0;
    end else begin
      int ix;
      bit err_evt;
      m_count_vld = 0; m_illegal = 0; m_seq_err = 0;
      err_evt = 0;
      if (code_vld) begin
        ix = lookup(code_in);
        if (ix < 0) begin
          m_illegal = 1; err_evt = 1;
          m_have_prev = 0; m_streak = 0;
        end else begin
          if (!m_have_prev) begin
            m_have_prev = 1; m_streak = 0;
          end else if (ix == (m_count + 1) % LEN) begin
            if (m_streak < 1000) m_streak++;
          end else if (m_streak >= LOCK_CNT) begin
            m_seq_err = 1; err_evt = 1;
            m_have_prev = 0; m_streak = 0;
          end else begin
            m_streak = 0;
          end
          m_count = ix;
          m_count_vld = 1;
        end
      end
      if (err_clr) m_err = 0;
      else if (err_evt && m_err < 255) m_err++;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("model_count", int'(count), m_count);
      checkOutput("model_count_vld", int'(count_vld), m_count_vld);
      checkOutput("model_illegal", int'(illegal), m_illegal);
      checkOutput("model_seq_err", int'(seq_err), m_seq_err);
      checkOutput("model_locked", int'(locked), int'(m_streak >= LOCK_CNT));
      checkOutput("model_err_cnt", int'(err_cnt), m_err);
    end
  end

  task automatic applyStimulus(input logic [3:0] code, input logic vld, input logic clr);
    @(negedge clk);
    code_in  = code;
    code_vld = vld;
    err_clr  = clr;
  endtask

  task automatic sampleWord(input logic [3:0] code);
    applyStimulus(code, 1'b1, 1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_count"}, int'(count), 0);
    checkOutput({tag, "_count_vld"}, int'(count_vld), 0);
    checkOutput({tag, "_illegal"}, int'(illegal), 0);
    checkOutput({tag, "_seq_err"}, int'(seq_err), 0);
    checkOutput({tag, "_locked"}, int'(locked), 0);
    checkOutput({tag, "_err_cnt"}, int'(err_cnt), 0);
  endtask

  initial begin
    rst_n = 1'b0; code_in = '0; code_vld = 1'b0; err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkAllZero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    check_en = 1;

    sampleWord(4'b0000);
    checkOutput("ring0_count", int'(count), 0);
    checkOutput("ring0_vld", int'(count_vld), 1);
    checkOutput("ring0_locked", int'(locked), 0);
    sampleWord(4'b1000);
    checkOutput("ring1_locked", int'(locked), 0);
    sampleWord(4'b1100);
    checkOutput("ring2_count", int'(count), 2);
    checkOutput("ring2_locked", int'(locked), 1);
    sampleWord(4'b1110);
    checkOutput("ring3_count", int'(count), 3);

    applyStimulus(4'b0101, 1'b0, 1'b0);
    @(posedge clk); #1;
    checkOutput("idle_vld", int'(count_vld), 0);
    checkOutput("idle_illegal", int'(illegal), 0);
    checkOutput("idle_locked", int'(locked), 1);

    sampleWord(4'b1010);
    checkOutput("bad_illegal", int'(illegal), 1);
    checkOutput("bad_err_cnt", int'(err_cnt), 1);
    checkOutput("bad_locked", int'(locked), 0);
    checkOutput("bad_count", int'(count), 3);

    sampleWord(4'b1110);
    sampleWord(4'b1111);
    sampleWord(4'b0111);
    checkOutput("relock_locked", int'(locked), 1);
    checkOutput("relock_count", int'(count), 5);
    sampleWord(4'b0011);
    sampleWord(4'b0001);
    checkOutput("pre_wrap_count", int'(count), 7);
    sampleWord(4'b0000);
    checkOutput("wrap_count", int'(count), 0);
    checkOutput("wrap_locked", int'(locked), 1);
    checkOutput("wrap_seq_err", int'(seq_err), 0);
    sampleWord(4'b1000);
    sampleWord(4'b1100);
    sampleWord(4'b1110);

    sampleWord(4'b0011);
    checkOutput("skip_seq_err", int'(seq_err), 1);
    checkOutput("skip_locked", int'(locked), 0);
    checkOutput("skip_count", int'(count), 6);
    checkOutput("skip_err_cnt", int'(err_cnt), 2);

    sampleWord(4'b0001);
    sampleWord(4'b0000);
    sampleWord(4'b1000);
    checkOutput("lock3_locked", int'(locked), 1);
    sampleWord(4'b1000);
    checkOutput("repeat_seq_err", int'(seq_err), 1);
    checkOutput("repeat_locked", int'(locked), 0);
    checkOutput("repeat_err_cnt", int'(err_cnt), 3);

    for (int i = 0; i < 300; i++) applyStimulus(4'b0100, 1'b1, 1'b0);
    @(posedge clk); #1;
    checkOutput("sat_err_cnt", int'(err_cnt), 255);
    checkOutput("sat_illegal", int'(illegal), 1);
    applyStimulus(4'b0100, 1'b1, 1'b1);
    @(posedge clk); #1;
    checkOutput("clr_err_cnt", int'(err_cnt), 0);
    checkOutput("clr_illegal", int'(illegal), 1);

    sampleWord(4'b0000);
    sampleWord(4'b1000);
    sampleWord(4'b1100);
    checkOutput("prerst_locked", int'(locked), 1);
    applyStimulus(4'b1110, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkAllZero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    sampleWord(4'b1100);
    checkOutput("post_rst_count", int'(count), 2);
    checkOutput("post_rst_vld", int'(count_vld), 1);
    checkOutput("post_rst_locked", int'(locked), 0);
    sampleWord(4'b1110);
    checkOutput("post_rst2_locked", int'(locked), 0);
    sampleWord(4'b1111);
    checkOutput("post_rst3_locked", int'(locked), 1);
    checkOutput("post_rst3_count", int'(count), 4);

    applyStimulus(4'b0000, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    #1;
    check_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
